sseg_scan_capture: RTL and testbench

SSEG_SCAN_CAPTURE -- requirements
Module: sseg_scan_capture

---
 rtl/sseg_pkg.sv | 33 +++
 rtl/sseg_glyph_decode.sv | 39 +++
 rtl/sseg_scan_capture.sv | 141 ++++++++++++++
 tb/tb_sseg_scan_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and glyph constants for the seven-segment scan capture block.
// Patterns are lit-high, segment a in bit 6 down to g in bit 0.
package sseg_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } glyph_t;

    localparam logic [6:0] G_0  = 7'b1111110;
    localparam logic [6:0] G_1  = 7'b0110000;
    localparam logic [6:0] G_2  = 7'b1101101;
    localparam logic [6:0] G_3  = 7'b1111001;
    localparam logic [6:0] G_4  = 7'b0110011;
    localparam logic [6:0] G_5  = 7'b1011011;
    localparam logic [6:0] G_6  = 7'b1011111;
    localparam logic [6:0] G_7A = 7'b1110000;
    localparam logic [6:0] G_7B = 7'b1110010;
    localparam logic [6:0] G_7C = 7'b1110001;
    localparam logic [6:0] G_8  = 7'b1111111;
    localparam logic [6:0] G_9A = 7'b1110011;
    localparam logic [6:0] G_9B = 7'b1111011;
    localparam logic [6:0] G_AA = 7'b1110111;
    localparam logic [6:0] G_AB = 7'b1111101;
    localparam logic [6:0] G_B  = 7'b0011111;
    localparam logic [6:0] G_CA = 7'b1001110;
    localparam logic [6:0] G_CB = 7'b0001101;
    localparam logic [6:0] G_D  = 7'b0111101;
    localparam logic [6:0] G_EA = 7'b1001111;
    localparam logic [6:0] G_EB = 7'b1101111;
    localparam logic [6:0] G_F  = 7'b1000111;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational glyph decoder: lit-high segment pattern to hex value.
// Any pattern outside the glyph table reports valid = 0.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] lit_i,
    output logic       valid_o,
    output logic [3:0] value_o
);

    glyph_t res;

    always_comb begin
        res = '{valid: 1'b1, value: 4'h0};
        case (lit_i)
            G_0:                res.value = 4'h0;
            G_1:                res.value = 4'h1;
            G_2:                res.value = 4'h2;
            G_3:                res.value = 4'h3;
            G_4:                res.value = 4'h4;
            G_5:                res.value = 4'h5;
            G_6:                res.value = 4'h6;
            G_7A, G_7B, G_7C:   res.value = 4'h7;
            G_8:                res.value = 4'h8;
            G_9A, G_9B:         res.value = 4'h9;
            G_AA, G_AB:         res.value = 4'hA;
            G_B:                res.value = 4'hB;
            G_CA, G_CB:         res.value = 4'hC;
            G_D:                res.value = 4'hD;
            G_EA, G_EB:         res.value = 4'hE;
            G_F:                res.value = 4'hF;
            default:            res.valid = 1'b0;
        endcase
    end

    assign valid_o = res.valid;
    assign value_o = res.value;

endmodule

// File: rtl/sseg_scan_capture.sv
// Recovers the hex digits shown on a multiplexed seven-segment display
// by sampling its drive lines and committing each digit once stable.
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter int STABLE_CNT     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            segments,
    input  logic                  dp,
    input  logic [N_DIGITS-1:0]   anodes,
    output logic [4*N_DIGITS-1:0] displayed_num,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [N_DIGITS-1:0]   dp_out,
    output logic                  frame_done,
    output logic                  err_pattern,
    output logic                  err_multi_anode
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [6:0]          seg_lit;
    logic                dp_lit;
    logic [N_DIGITS-1:0] an_sel;
    logic                multi;
    logic                single;
    logic [IW-1:0]       idx;
    logic                dec_valid;
    logic [3:0]          dec_value;
    logic [4:0]          sample;
    logic                hit;
    logic [CW-1:0]       cur_cnt;
    logic [CW-1:0]       cnt_d;
    logic                commit;
    logic [N_DIGITS-1:0] seen_d;

    logic [4*N_DIGITS-1:0] disp_q;
    logic [N_DIGITS-1:0]   valid_q;
    logic [N_DIGITS-1:0]   dpo_q;
    logic [N_DIGITS-1:0]   seen_q;
    logic                  frame_q;
    logic                  errp_q;
    logic                  errm_q;
    logic [4:0]            cand_q [N_DIGITS];
    logic [CW-1:0]         cnt_q  [N_DIGITS];

    assign seg_lit = SEG_ACTIVE_LOW ? ~segments : segments;
    assign dp_lit  = SEG_ACTIVE_LOW ? ~dp : dp;
    assign an_sel  = AN_ACTIVE_LOW ? ~anodes : anodes;

    // Power-of-two test: more than one bit set means a scan overlap.
    assign multi  = (an_sel & (an_sel - 1'b1)) != '0;
    assign single = (|an_sel) && !multi;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (an_sel[i]) idx = IW'(i);
        end
    end

    sseg_glyph_decode u_dec (
        .lit_i   (seg_lit),
        .valid_o (dec_valid),
        .value_o (dec_value)
    );

    assign sample  = {dec_value, dp_lit};
    assign hit     = (cand_q[idx] == sample);
    assign cur_cnt = cnt_q[idx];
    assign seen_d  = seen_q | an_sel;

    always_comb begin
        cnt_d = CNT_ONE;
        if (hit) begin
            cnt_d = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CNT_ONE;
        end
    end

    assign commit = (cnt_d == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q  <= '0;
            valid_q <= '0;
            dpo_q   <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            errp_q  <= 1'b0;
            errm_q  <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                cand_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            frame_q <= 1'b0;
            errp_q  <= 1'b0;
            errm_q  <= 1'b0;
            if (multi) begin
                errm_q <= 1'b1;
                for (int i = 0; i < N_DIGITS; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (single) begin
                if (!dec_valid) begin
                    errp_q     <= 1'b1;
                    cnt_q[idx] <= '0;
                end else begin
                    cand_q[idx] <= sample;
                    cnt_q[idx]  <= cnt_d;
                    if (commit) begin
                        disp_q[4*idx +: 4] <= dec_value;
                        dpo_q[idx]         <= dp_lit;
                        valid_q[idx]       <= 1'b1;
                    end
                    if (&seen_d) begin
                        frame_q <= 1'b1;
                        seen_q  <= '0;
                    end else begin
                        seen_q <= seen_d;
                    end
                end
            end
        end
    end

    assign displayed_num   = disp_q;
    assign digit_valid     = valid_q;
    assign dp_out          = dpo_q;
    assign frame_done      = frame_q;
    assign err_pattern     = errp_q;
    assign err_multi_anode = errm_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed vector bench for sseg_scan_capture with 4 digits, active-low
// drive and a stability window of 3 samples.
module tb_sseg_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic [15:0] displayed_num;
    logic [3:0]  digit_valid;
    logic [3:0]  dp_out;
    logic        frame_done;
    logic        err_pattern;
    logic        err_multi_anode;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sseg_scan_capture #(
        .N_DIGITS       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1),
        .STABLE_CNT     (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .segments        (segments),
        .dp              (dp),
        .anodes          (anodes),
        .displayed_num   (displayed_num),
        .digit_valid     (digit_valid),
        .dp_out          (dp_out),
        .frame_done      (frame_done),
        .err_pattern     (err_pattern),
        .err_multi_anode (err_multi_anode)
    );

    // Active-low drive patterns (abcdefg, 0 = lit).
    localparam logic [6:0] S_1   = 7'b1001111;
    localparam logic [6:0] S_2   = 7'b0010010;
    localparam logic [6:0] S_3   = 7'b0000110;
    localparam logic [6:0] S_4   = 7'b1001100;
    localparam logic [6:0] S_5   = 7'b0100100;
    localparam logic [6:0] S_8   = 7'b0000000;
    localparam logic [6:0] S_7B  = 7'b0001101;
    localparam logic [6:0] S_7C  = 7'b0001110;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_BAD = 7'b1111110;
    localparam logic [6:0] S_OFF = 7'b1111111;

    localparam logic [3:0] A_0   = 4'b1110;
    localparam logic [3:0] A_1   = 4'b1101;
    localparam logic [3:0] A_2   = 4'b1011;
    localparam logic [3:0] A_3   = 4'b0111;
    localparam logic [3:0] A_NO  = 4'b1111;

    typedef struct {
        logic        rst;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] disp;
        logic [3:0]  vld;
        logic [3:0]  dpo;
        logic        fd;
        logic        ep;
        logic        em;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] an,
                       input logic [6:0] seg, input logic d,
                       input logic [15:0] disp, input logic [3:0] vld,
                       input logic [3:0] dpo, input logic fd,
                       input logic ep, input logic em);
        vec_t v;
        v.rst = r;   v.an = an;   v.seg = seg; v.dp = d;
        v.disp = disp; v.vld = vld; v.dpo = dpo;
        v.fd = fd;   v.ep = ep;   v.em = em;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; anodes = A_NO; segments = S_OFF; dp = 1'b1;

        // rst an seg dp | disp vld dpo fd ep em
        add(1, A_NO, S_OFF, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        // digit 0 shows 2 for three samples
        add(0, A_0, S_2, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        add(0, A_0, S_2, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        add(0, A_0, S_2, 1, 16'h0002, 4'h1, 4'h0, 0, 0, 0);
        // digit 1 only two samples, then a different glyph
        add(0, A_1, S_1, 1, 16'h0002, 4'h1, 4'h0, 0, 0, 0);
        add(0, A_1, S_1, 1, 16'h0002, 4'h1, 4'h0, 0, 0, 0);
        add(0, A_1, S_3, 1, 16'h0002, 4'h1, 4'h0, 0, 0, 0);
        // scan 1,2,3,4 across digits 0..3
        add(0, A_0, S_1, 1, 16'h0002, 4'h1, 4'h0, 0, 0, 0);
        add(0, A_0, S_1, 1, 16'h0002, 4'h1, 4'h0, 0, 0, 0);
        add(0, A_0, S_1, 1, 16'h0001, 4'h1, 4'h0, 0, 0, 0);
        add(0, A_1, S_2, 1, 16'h0001, 4'h1, 4'h0, 0, 0, 0);
        add(0, A_1, S_2, 1, 16'h0001, 4'h1, 4'h0, 0, 0, 0);
        add(0, A_1, S_2, 1, 16'h0021, 4'h3, 4'h0, 0, 0, 0);
        add(0, A_2, S_3, 1, 16'h0021, 4'h3, 4'h0, 0, 0, 0);
        add(0, A_2, S_3, 1, 16'h0021, 4'h3, 4'h0, 0, 0, 0);
        add(0, A_2, S_3, 1, 16'h0321, 4'h7, 4'h0, 0, 0, 0);
        add(0, A_3, S_4, 1, 16'h0321, 4'h7, 4'h0, 1, 0, 0);
        add(0, A_3, S_4, 1, 16'h0321, 4'h7, 4'h0, 0, 0, 0);
        add(0, A_3, S_4, 1, 16'h4321, 4'hF, 4'h0, 0, 0, 0);
        add(0, A_NO, S_4, 1, 16'h4321, 4'hF, 4'h0, 0, 0, 0);
        // two samples of 5, overlap clears counts, restart needs three
        add(0, A_0, S_5, 1, 16'h4321, 4'hF, 4'h0, 0, 0, 0);
        add(0, A_0, S_5, 1, 16'h4321, 4'hF, 4'h0, 0, 0, 0);
        add(0, 4'b1100, S_5, 1, 16'h4321, 4'hF, 4'h0, 0, 0, 1);
        add(0, A_0, S_5, 1, 16'h4321, 4'hF, 4'h0, 0, 0, 0);
        add(0, A_0, S_5, 1, 16'h4321, 4'hF, 4'h0, 0, 0, 0);
        add(0, A_0, S_5, 1, 16'h4325, 4'hF, 4'h0, 0, 0, 0);
        // bad glyph, then bad glyph with all anodes on
        add(0, A_1, S_BAD, 1, 16'h4325, 4'hF, 4'h0, 0, 1, 0);
        add(0, A_NO, S_BAD, 1, 16'h4325, 4'hF, 4'h0, 0, 0, 0);
        add(0, 4'b0000, S_BAD, 1, 16'h4325, 4'hF, 4'h0, 0, 0, 1);
        // 8 with dp lit on digit 0, alternate 7 glyphs on digits 1,2
        add(0, A_0, S_8, 0, 16'h4325, 4'hF, 4'h0, 0, 0, 0);
        add(0, A_0, S_8, 0, 16'h4325, 4'hF, 4'h0, 0, 0, 0);
        add(0, A_0, S_8, 0, 16'h4328, 4'hF, 4'h1, 0, 0, 0);
        add(0, A_1, S_7B, 1, 16'h4328, 4'hF, 4'h1, 0, 0, 0);
        add(0, A_1, S_7B, 1, 16'h4328, 4'hF, 4'h1, 0, 0, 0);
        add(0, A_1, S_7B, 1, 16'h4378, 4'hF, 4'h1, 0, 0, 0);
        add(0, A_2, S_7C, 1, 16'h4378, 4'hF, 4'h1, 1, 0, 0);
        add(0, A_2, S_7C, 1, 16'h4378, 4'hF, 4'h1, 0, 0, 0);
        add(0, A_2, S_7C, 1, 16'h4778, 4'hF, 4'h1, 0, 0, 0);
        // reset inside a stability window discards the partial count
        add(0, A_3, S_8, 1, 16'h4778, 4'hF, 4'h1, 0, 0, 0);
        add(0, A_3, S_8, 1, 16'h4778, 4'hF, 4'h1, 0, 0, 0);
        add(1, A_3, S_8, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        add(0, A_3, S_8, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        add(0, A_3, S_8, 1, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
        add(0, A_3, S_8, 1, 16'h8000, 4'h8, 4'h0, 0, 0, 0);

        foreach (vecs[k]) begin
            rst = vecs[k].rst; anodes = vecs[k].an;
            segments = vecs[k].seg; dp = vecs[k].dp;
            @(posedge clk);
            #1;
            chk("displayed_num", k, displayed_num, vecs[k].disp);
            chk("digit_valid", k, 16'(digit_valid), 16'(vecs[k].vld));
            chk("dp_out", k, 16'(dp_out), 16'(vecs[k].dpo));
            chk("frame_done", k, 16'(frame_done), 16'(vecs[k].fd));
            chk("err_pattern", k, 16'(err_pattern), 16'(vecs[k].ep));
            chk("err_multi_anode", k, 16'(err_multi_anode),
                16'(vecs[k].em));
        end

        // Hold A on digit 2 and count samples until it commits.
        rst = 1'b0; anodes = A_2; segments = S_A; dp = 1'b1;
        n = 0;
        while (!digit_valid[2] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("commit_latency", 99, 16'(n), 16'd3);
        chk("digit2_value", 99, 16'(displayed_num[11:8]), 16'hA);
        anodes = A_NO;
        @(posedge clk);
        #1;
        chk("blank_hold", 100, displayed_num, 16'h8A00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
